calc_input_stage: RTL



---
 rtl/calc_input_stage_if.sv | 22 ++
 rtl/calc_input_stage.sv | 92 +++++++++
 2 files changed

// File: rtl/calc_input_stage_if.sv
// Calculator front-end bundle: raw switches/buttons in, latched operands out.
// master drives sw/btn and observes a/b/op/op_valid; slave is the stage.
interface calc_input_stage_if #(
    parameter int BITS = 4
);
    logic [2*BITS-1:0] sw;
    logic [3:0]        btn;
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [3:0]        op;
    logic              op_valid;

    modport master (
        output sw, btn,
        input  a, b, op, op_valid
    );

    modport slave (
        input  sw, btn,
        output a, b, op, op_valid
    );
endinterface

// File: rtl/calc_input_stage.sv
// Synchronises switches/buttons, debounces buttons, latches a/b/op on press.
// Ports: clk, rst_n (sync, active-low), io (slave): sw, btn -> a, b, op, op_valid.
// Option: define CALC_IN_TOGGLE_EN to let a repeat press of the active op clear it.
module calc_input_stage #(
    parameter int BITS            = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    calc_input_stage_if.slave       io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [2*BITS-1:0] sw_s1, sw_s2;
    logic [3:0]        btn_s1, btn_s2;
    logic [3:0]        st;
    logic [CW-1:0]     cnt [4];

    logic [BITS-1:0]   a_q, b_q;
    logic [3:0]        op_q;
    logic              op_valid_q;

    logic [3:0]        term;
    logic [3:0]        press;
    logic [3:0]        sel;
    logic [3:0]        next_op;

    // term: button has disagreed with its stable state long enough to flip
    always_comb begin
        term  = '0;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            term[i]  = (btn_s2[i] != st[i]) && (cnt[i] == TERM);
            press[i] = term[i] && btn_s2[i];
        end
    end

    // isolate lowest set bit so the lowest-index button wins
    assign sel = press & (~press + 4'd1);

`ifdef CALC_IN_TOGGLE_EN
    assign next_op = (op_q == sel) ? 4'd0 : sel;
`else
    assign next_op = sel;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            btn_s1     <= '0;
            btn_s2     <= '0;
            st         <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
        end else begin
            sw_s1  <= io.sw;
            sw_s2  <= sw_s1;
            btn_s1 <= io.btn;
            btn_s2 <= btn_s1;

            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (term[i]) begin
                    st[i]  <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end

            op_valid_q <= |press;
            if (|press) begin
                a_q  <= sw_s2[2*BITS-1:BITS];
                b_q  <= sw_s2[BITS-1:0];
                op_q <= next_op;
            end
        end
    end

    assign io.a        = a_q;
    assign io.b        = b_q;
    assign io.op       = op_q;
    assign io.op_valid = op_valid_q;
endmodule
